hmmm_alu_sequencer: RTL and testbench
=====================================

Name: hmmm_alu_sequencer

Overview:
Execute-stage controller that drives the Hmmm ALU from the operand side. It accepts a decoded arithmetic request and reads the source registers through the register-file read port. It presents the operands to the ALU's tmp1/tmp2/op/enable inputs, captures result, zero and carry, and writes the result back to the register file. It sits between the instruction decoder and the ALU/register file inside the Hmmm core.

Parameters:
DATA_W, 16, datapath width (register, immediate, ALU operand/result)
REG_AW, 4, register address width (r0..r15)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  decoder request valid
req_ready  out  1  sequencer can accept a request
req_op  in  3  ALU op code, passed through unmodified
req_rd  in  REG_AW  destination register
req_ra  in  REG_AW  source register A
req_rb  in  REG_AW  source register B (ignored when req_imm_en=1)
req_imm_en  in  1  use req_imm as operand B
req_imm  in  DATA_W  immediate operand B (already sign-extended by decoder)
rf_raddr  out  REG_AW  register-file read address
rf_rdata  in  DATA_W  register-file read data, synchronous, 1-cycle latency
rf_we  out  1  register-file write enable
rf_waddr  out  REG_AW  write address
rf_wdata  out  DATA_W  write data
alu_tmp1  out  DATA_W  ALU operand A
alu_tmp2  out  DATA_W  ALU operand B
alu_op  out  3  ALU op
alu_enable  out  1  ALU enable
alu_result  in  DATA_W  ALU result (combinational)
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry flag
flag_zero  out  1  architectural zero flag
flag_carry  out  1  architectural carry flag
busy  out  1  operation in progress
done  out  1  one-cycle pulse at writeback

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE and every output is 0, including registered tmp1/tmp2/op and both flags. Exception: req_ready reads 1 once in IDLE.
- States: IDLE, RD_A, RD_B, LD_B, EXEC, WB.
- IDLE: req_ready=1 and busy=0. On req_valid=1, latch all req_* fields and go to RD_A.
- RD_A: rf_raddr=ra. Go to RD_B.
- RD_B: alu_tmp1 <= (ra==0) ? 0 : rf_rdata.
  - If imm_en=1: alu_tmp2 <= imm; go to EXEC.
  - Otherwise: rf_raddr=rb; go to LD_B.
- LD_B: alu_tmp2 <= (rb==0) ? 0 : rf_rdata. Go to EXEC.
- EXEC: alu_enable=1 and alu_op=op. Capture alu_result, alu_zero and alu_carry into internal registers. Go to WB.
- WB: rf_waddr=rd, rf_wdata=captured result, rf_we=(rd!=0). done=1 for exactly this cycle. flag_zero/flag_carry <= captured values. Go to IDLE.
- rf_raddr is 0 in all states other than RD_A/RD_B.
- busy = (state != IDLE). req_ready = (state == IDLE).
- Requests presented while busy are ignored. They are neither queued nor lost; the decoder holds req_valid.
- Latency, with the accept edge at cycle 0:
  - Register form: WB at cycle 5.
  - Immediate form: WB at cycle 4.
  - Next accept possible at cycle 6 (register form) or cycle 5 (immediate form).
- alu_tmp1, alu_tmp2 and alu_op hold their last values after EXEC until overwritten.
- No arithmetic happens here. Result and flags pass through at DATA_W bits with no extension. Carry is taken from the ALU as-is.
- r0 handling:
  - Reads of r0 are forced to 0 regardless of rf_rdata.
  - Writes to rd=0 are suppressed.
  - done still pulses and the flags still update.
- Reset asserted mid-operation aborts immediately to IDLE. No rf_we is issued, flags clear to 0, and done is not pulsed.

Test Plan:
Bench ALU model: op 0 = 16-bit add, carry = unsigned carry-out, zero = (result==0). Register file is a 16x16 sync-read model.
1. Hold rst_n=0, then release -> all outputs 0, req_ready=1, busy=0.
2. r1=0xFFFF, r2=0xFFFE; request op0, rd=3, ra=1, rb=2 -> alu_tmp1=0xFFFF and alu_tmp2=0xFFFE at EXEC; rf_we to r3 with 0xFFFD at cycle 5; flag_carry=1, flag_zero=0.
3. r1=0x7FFF; immediate request op0, imm 0x0002, rd=4 -> writeback 0x8001 at cycle 4; carry=0, zero=0.
4. r1=0x0003; immediate 0xFFFD, rd=0 -> result 0, flag_zero=1, flag_carry=1; rf_we never asserted; done pulses once.
5. ra=0 with register-file model returning 0x1234 at address 0 -> alu_tmp1=0x0000. Second request is issued with req_valid held from cycle 1 -> not accepted until req_ready is high in IDLE; second writeback follows the first done.
6. Assert rst_n=0 while in LD_B -> state IDLE immediately, rf_we stays 0, done stays 0, flags are 0; a fresh request after release completes normally.

Source files
------------

// File: rtl/hmmm_alu_sequencer_if.sv
// Decoder request, register-file port and ALU operand/result bundle seen by the
// Hmmm execute-stage sequencer. The master side is the surrounding core.
interface hmmm_alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [REG_AW-1:0] req_rd;
  logic [REG_AW-1:0] req_ra;
  logic [REG_AW-1:0] req_rb;
  logic              req_imm_en;
  logic [DATA_W-1:0] req_imm;

  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] alu_tmp1;
  logic [DATA_W-1:0] alu_tmp2;
  logic [2:0]        alu_op;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;

  modport master (
    output req_valid, req_op, req_rd, req_ra, req_rb, req_imm_en, req_imm,
    input  req_ready,
    input  rf_raddr, rf_we, rf_waddr, rf_wdata,
    output rf_rdata,
    input  alu_tmp1, alu_tmp2, alu_op, alu_enable,
    output alu_result, alu_zero, alu_carry
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_ra, req_rb, req_imm_en, req_imm,
    output req_ready,
    output rf_raddr, rf_we, rf_waddr, rf_wdata,
    input  rf_rdata,
    output alu_tmp1, alu_tmp2, alu_op, alu_enable,
    input  alu_result, alu_zero, alu_carry
  );
endinterface

// File: rtl/hmmm_alu_sequencer.sv
// Hmmm execute-stage sequencer: fetches operands from the register file, drives
// the ALU for one cycle, captures result/flags and writes the result back.
module hmmm_alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hmmm_alu_sequencer_if.slave  bus,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LD_B, EXEC, WB} state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } req_t;

  state_t            st, st_nx;
  req_t              rq;
  logic [DATA_W-1:0] tmp1, tmp2, res_q;
  logic [2:0]        op_q;
  logic              z_q, c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      rq         <= '0;
      tmp1       <= '0;
      tmp2       <= '0;
      op_q       <= '0;
      res_q      <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      st <= st_nx;
      case (st)
        IDLE: if (bus.req_valid) begin
          rq.op     <= bus.req_op;
          rq.rd     <= bus.req_rd;
          rq.ra     <= bus.req_ra;
          rq.rb     <= bus.req_rb;
          rq.imm_en <= bus.req_imm_en;
          rq.imm    <= bus.req_imm;
        end
        // rf_rdata here answers the ra read issued in RD_A; r0 always reads zero
        RD_B: begin
          tmp1 <= (rq.ra == '0) ? '0 : bus.rf_rdata;
          op_q <= rq.op;
          if (rq.imm_en) tmp2 <= rq.imm;
        end
        LD_B: tmp2 <= (rq.rb == '0) ? '0 : bus.rf_rdata;
        EXEC: begin
          res_q <= bus.alu_result;
          z_q   <= bus.alu_zero;
          c_q   <= bus.alu_carry;
        end
        WB: begin
          flag_zero  <= z_q;
          flag_carry <= c_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nx          = st;
    bus.rf_raddr   = '0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;
    bus.alu_enable = 1'b0;
    done           = 1'b0;
    case (st)
      IDLE: if (bus.req_valid) st_nx = RD_A;
      RD_A: begin
        bus.rf_raddr = rq.ra;
        st_nx        = RD_B;
      end
      RD_B: begin
        bus.rf_raddr = rq.imm_en ? '0 : rq.rb;
        st_nx        = rq.imm_en ? EXEC : LD_B;
      end
      LD_B: st_nx = EXEC;
      EXEC: begin
        bus.alu_enable = 1'b1;
        st_nx          = WB;
      end
      WB: begin
        bus.rf_we    = (rq.rd != '0);
        bus.rf_waddr = rq.rd;
        bus.rf_wdata = res_q;
        done         = 1'b1;
        st_nx        = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  assign bus.req_ready = (st == IDLE);
  assign busy          = (st != IDLE);
  assign bus.alu_tmp1  = tmp1;
  assign bus.alu_tmp2  = tmp2;
  assign bus.alu_op    = op_q;

endmodule

// File: tb/tb_hmmm_alu_sequencer.sv
// Directed bench for hmmm_alu_sequencer with a 16x16 sync-read register file
// and an add-only ALU model.
module tb_hmmm_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flag_zero, flag_carry, busy, done;

  hmmm_alu_sequencer_if #(.DATA_W(16), .REG_AW(4)) b();

  hmmm_alu_sequencer #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;

  always @(posedge clk) begin
    b.rf_rdata <= rf[b.rf_raddr];
    if (b.rf_we)  rf[b.rf_waddr] <= b.rf_wdata;
    if (pre_we)   rf[pre_a]      <= pre_d;
  end

  assign {b.alu_carry, b.alu_result} = {1'b0, b.alu_tmp1} + {1'b0, b.alu_tmp2};
  assign b.alu_zero = (b.alu_result == 16'h0);

  int we_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (b.rf_we) we_cnt <= we_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  int          r_wb;
  logic [15:0] r_t1, r_t2, r_wd;
  logic [3:0]  r_wa;
  logic        r_we;

  // r_wb is the clock edge (accept edge = 0) at which the writeback commits
  task automatic issue(input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                       input logic ie, input logic [15:0] imm);
    int w;
    r_wb = -1; r_t1 = '0; r_t2 = '0; r_wd = '0; r_wa = '0; r_we = 1'b0;
    @(negedge clk);
    b.req_op = 3'd0; b.req_rd = rd; b.req_ra = ra; b.req_rb = rb;
    b.req_imm_en = ie; b.req_imm = imm; b.req_valid = 1'b1;
    w = 0;
    while (!b.req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b.alu_enable) begin r_t1 = b.alu_tmp1; r_t2 = b.alu_tmp2; end
      if (done) begin
        r_wb = n + 1; r_wd = b.rf_wdata; r_wa = b.rf_waddr; r_we = b.rf_we;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  int d1, d2, dn, acc, wc0, dc0;
  logic [15:0] t1_first;
  logic drop;

  initial begin
    b.req_valid = 1'b0; b.req_op = '0; b.req_rd = '0; b.req_ra = '0;
    b.req_rb = '0; b.req_imm_en = 1'b0; b.req_imm = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", {b.rf_raddr, b.rf_we, b.rf_waddr, b.rf_wdata[7:0], b.alu_enable,
                     b.alu_op, flag_zero, flag_carry, busy, done}, 32'h0);
    chk("rst_tmp", {b.alu_tmp1, b.alu_tmp2}, 32'h0);
    chk("rst_ready", b.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {b.req_ready, busy}, 32'h2);

    // 2: register form with carry
    preload(4'd1, 16'hFFFF);
    preload(4'd2, 16'hFFFE);
    issue(4'd3, 4'd1, 4'd2, 1'b0, 16'h0);
    chk("t2_tmp1", r_t1, 16'hFFFF);
    chk("t2_tmp2", r_t2, 16'hFFFE);
    chk("t2_wb_edge", r_wb, 5);
    chk("t2_wr", {r_we, r_wa, r_wd}, {1'b1, 4'd3, 16'hFFFD});
    chk("t2_flags", {flag_carry, flag_zero}, 2'b10);
    chk("t2_rf3", rf[3], 16'hFFFD);
    chk("t2_idle", {b.req_ready, busy, done}, 3'b100);

    // 3: immediate form, signed overflow but no carry
    preload(4'd1, 16'h7FFF);
    issue(4'd4, 4'd1, 4'd9, 1'b1, 16'h0002);
    chk("t3_wb_edge", r_wb, 4);
    chk("t3_wr", {r_we, r_wa, r_wd}, {1'b1, 4'd4, 16'h8001});
    chk("t3_tmp2", r_t2, 16'h0002);
    chk("t3_flags", {flag_carry, flag_zero}, 2'b00);

    // 4: rd=0 suppresses write but still pulses done and updates flags
    preload(4'd1, 16'h0003);
    wc0 = we_cnt; dc0 = done_cnt;
    issue(4'd0, 4'd1, 4'd0, 1'b1, 16'hFFFD);
    chk("t4_wd", r_wd, 16'h0000);
    chk("t4_flags", {flag_carry, flag_zero}, 2'b11);
    chk("t4_no_we", we_cnt - wc0, 0);
    chk("t4_done_once", done_cnt - dc0, 1);

    // 5: r0 read forced to 0, second request held from cycle 1
    preload(4'd0, 16'h1234);
    @(negedge clk);
    b.req_op = 3'd0; b.req_rd = 4'd5; b.req_ra = 4'd0; b.req_rb = 4'd1;
    b.req_imm_en = 1'b0; b.req_imm = '0; b.req_valid = 1'b1;
    @(posedge clk);
    #1 b.req_rd = 4'd6; b.req_ra = 4'd5; b.req_imm_en = 1'b1; b.req_imm = 16'h0010;
    d1 = -1; d2 = -1; dn = 0; acc = -1; t1_first = 16'hDEAD; drop = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b.alu_enable && dn == 0) t1_first = b.alu_tmp1;
      if (done) begin
        if (dn == 0) d1 = n + 1; else d2 = n + 1;
        dn++;
      end
      if (b.req_ready && b.req_valid && acc < 0) begin acc = n + 1; drop = 1'b1; end
      @(posedge clk);
      if (drop) begin #1 b.req_valid = 1'b0; drop = 1'b0; end
    end
    chk("t5_tmp1_r0", t1_first, 16'h0000);
    chk("t5_done1", d1, 5);
    chk("t5_accept2", acc, 6);
    chk("t5_done2", d2, 10);
    chk("t5_rf5", rf[5], 16'h0003);
    chk("t5_rf6", rf[6], 16'h0013);

    // 6: reset in LD_B aborts; set flags first so the clear is visible
    issue(4'd0, 4'd1, 4'd0, 1'b1, 16'hFFFD);
    chk("t6_pre_flags", {flag_carry, flag_zero}, 2'b11);
    preload(4'd2, 16'hFFFE);
    wc0 = we_cnt; dc0 = done_cnt;
    @(negedge clk);
    b.req_rd = 4'd7; b.req_ra = 4'd1; b.req_rb = 4'd2; b.req_imm_en = 1'b0;
    b.req_valid = 1'b1;
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_busy_ldb", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_abort", {b.req_ready, busy, done, b.rf_we, flag_zero, flag_carry}, 6'b100000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t6_no_we", we_cnt - wc0, 0);
    chk("t6_no_done", done_cnt - dc0, 0);
    issue(4'd7, 4'd1, 4'd2, 1'b0, 16'h0);
    chk("t6_wb_edge", r_wb, 5);
    chk("t6_rf7", rf[7], 16'h0001);
    chk("t6_flags", {flag_carry, flag_zero}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
